// File: rtl/bhg_jt49_pkg.sv
// Shared definitions for the JT49 PSG envelope path.
//   env_state_e : envelope state machine encoding (RUN / HOLD)
//   ENV_MAX     : top of the 5-bit envelope level range
//   SHAPE_*     : bit positions inside the 4-bit envelope shape register
//   env_level   : maps a step count and direction onto an output level
package bhg_jt49_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } env_state_e;

  localparam logic [4:0] ENV_MAX = 5'd31;

  localparam int unsigned SHAPE_CONT = 3;
  localparam int unsigned SHAPE_ATT  = 2;
  localparam int unsigned SHAPE_ALT  = 1;
  localparam int unsigned SHAPE_HOLD = 0;

  function automatic logic [4:0] env_level(input logic [4:0] step, input logic dir);
    return dir ? step : (ENV_MAX - step);
  endfunction

endpackage

// File: rtl/bhg_jt49_period_div.sv
// Tick divider shared by the envelope, tone and noise generators.
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : input tick enable
//   clr        : synchronous clear; wins over a coincident cen (tick dropped)
//   period     : ticks per output step; 0 behaves as 1
//   step       : combinational one-clk pulse on the tick that completes a period
module bhg_jt49_period_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  output logic             step
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit;

  // >= rather than == so shrinking the period mid-count steps on the next tick
  always_comb begin
    limit = (period == '0) ? '0 : (period - ONE);
    step  = cen && !clr && (cnt_q >= limit);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cen) begin
      cnt_d = step ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bhg_jt49_env_gen.sv
// JT49 envelope generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : PSG envelope tick enable (one clk wide)
//   eg_period  : envelope period in cen ticks per step
//   shape      : {continue, attack, alternate, hold}, latched on shape_wr
//   shape_wr   : one-clk pulse; latches shape and restarts the envelope
//   env        : registered 5-bit envelope level
//   env_step   : registered pulse on each cycle the envelope advances
//   env_held   : high while in HOLD
module bhg_jt49_env_gen
  import bhg_jt49_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [PERIOD_BITS-1:0] eg_period,
  input  logic [3:0]             shape,
  input  logic                   shape_wr,
  output logic [4:0]             env,
  output logic                   env_step,
  output logic                   env_held
);

  env_state_e state_q, state_d;
  logic [3:0] shape_q, shape_d;
  logic [4:0] step_cnt_q, step_cnt_d;
  logic [4:0] env_q, env_d;
  logic       dir_q, dir_d;
  logic       env_step_q, env_step_d;
  logic       pd_step;

  bhg_jt49_period_div #(
    .WIDTH(PERIOD_BITS)
  ) u_period_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .clr   (shape_wr),
    .period(eg_period),
    .step  (pd_step)
  );

  always_comb begin
    state_d    = state_q;
    shape_d    = shape_q;
    step_cnt_d = step_cnt_q;
    env_d      = env_q;
    dir_d      = dir_q;
    env_step_d = 1'b0;
    if (shape_wr) begin
      shape_d    = shape;
      step_cnt_d = '0;
      dir_d      = shape[SHAPE_ATT];
      state_d    = ST_RUN;
      env_d      = env_level(5'd0, shape[SHAPE_ATT]);
    end else if (state_q == ST_RUN && pd_step) begin
      env_step_d = 1'b1;
      if (step_cnt_q == ENV_MAX) begin
        step_cnt_d = '0;
        if (!shape_q[SHAPE_CONT] || shape_q[SHAPE_HOLD]) begin
          state_d = ST_HOLD;
          // Hold ends the first sweep, so dir still equals attack here and the
          // final level is all-ones or all-zeros; alternate then inverts it.
          env_d = shape_q[SHAPE_CONT]
                ? ({5{shape_q[SHAPE_ATT]}} ^ {5{shape_q[SHAPE_ALT]}})
                : 5'd0;
        end else begin
          dir_d = shape_q[SHAPE_ALT] ? !dir_q : dir_q;
          env_d = env_level(5'd0, dir_d);
        end
      end else begin
        step_cnt_d = step_cnt_q + 5'd1;
        env_d      = env_level(step_cnt_d, dir_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HOLD;
      shape_q    <= '0;
      step_cnt_q <= '0;
      env_q      <= '0;
      dir_q      <= 1'b0;
      env_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shape_q    <= shape_d;
      step_cnt_q <= step_cnt_d;
      env_q      <= env_d;
      dir_q      <= dir_d;
      env_step_q <= env_step_d;
    end
  end

  assign env      = env_q;
  assign env_step = env_step_q;
  assign env_held = (state_q == ST_HOLD);

endmodule

// File: tb/tb_bhg_jt49_env_gen.sv
module tb_bhg_jt49_env_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [15:0] eg_period = 16'd1;
  logic [3:0]  shape = 4'd0;
  logic        shape_wr = 1'b0;
  logic [4:0]  env;
  logic        env_step;
  logic        env_held;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bhg_jt49_env_gen #(
    .PERIOD_BITS(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .eg_period(eg_period),
    .shape    (shape),
    .shape_wr (shape_wr),
    .env      (env),
    .env_step (env_step),
    .env_held (env_held)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_shape(input logic [3:0] s, input logic with_cen);
    shape    = s;
    shape_wr = 1'b1;
    cen      = with_cen;
    cyc();
    shape_wr = 1'b0;
    cen      = 1'b0;
  endtask

  // Pulses cen until env_step is seen; ncen = ticks used, or -1 on timeout.
  task automatic step_wait(input int max_cen, output int ncen);
    ncen = -1;
    for (int i = 1; i <= max_cen; i++) begin
      cen = 1'b1;
      cyc();
      cen = 1'b0;
      if (env_step) begin
        ncen = i;
        return;
      end
    end
  endtask

  task automatic run_steps(input int n);
    int nc;
    for (int k = 0; k < n; k++) begin
      step_wait(8, nc);
      check("step_timeout", nc, 1);
    end
  endtask

  int nc;
  int seen;
  int exp_lvl;

  initial begin
    // reset state
    #2;
    check("rst_env", env, 0);
    check("rst_held", env_held, 1);
    check("rst_step", env_step, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cen = 1'b1;
      cyc();
      cen = 1'b0;
      if (env_step) seen++;
    end
    check("idle_steps", seen, 0);
    check("idle_env", env, 0);
    check("idle_held", env_held, 1);

    // 1101, period 2: rising 0..31, then hold 31
    eg_period = 16'd2;
    write_shape(4'b1101, 1'b0);
    check("att_first", env, 0);
    check("att_held0", env_held, 0);
    check("att_nostep", env_step, 0);
    for (int k = 1; k <= 31; k++) begin
      step_wait(4, nc);
      check("att_ncen", nc, 2);
      check("att_env", env, k);
    end
    step_wait(4, nc);
    check("att_wrap_ncen", nc, 2);
    check("att_hold_env", env, 31);
    check("att_hold_flag", env_held, 1);
    step_wait(10, nc);
    check("att_hold_nostep", nc, -1);
    check("att_hold_env2", env, 31);

    // 1010, period 1: triangle 31..0, 0..31, ... never holding
    eg_period = 16'd1;
    write_shape(4'b1010, 1'b0);
    check("tri_first", env, 31);
    for (int k = 1; k <= 200; k++) begin
      step_wait(4, nc);
      check("tri_ncen", nc, 1);
      exp_lvl = ((k % 64) < 32) ? (31 - (k % 64)) : ((k % 64) - 32);
      check("tri_env", env, exp_lvl);
      check("tri_held", env_held, 0);
    end

    // 0000: falling, then hold 0
    write_shape(4'b0000, 1'b0);
    check("s0000_first", env, 31);
    run_steps(31);
    check("s0000_last", env, 0);
    run_steps(1);
    check("s0000_env", env, 0);
    check("s0000_held", env_held, 1);

    // 1111: rising, then hold inverted level 0
    write_shape(4'b1111, 1'b0);
    check("s1111_first", env, 0);
    run_steps(31);
    check("s1111_last", env, 31);
    run_steps(1);
    check("s1111_env", env, 0);
    check("s1111_held", env_held, 1);

    // 1011: falling, then hold inverted level 31
    write_shape(4'b1011, 1'b0);
    run_steps(32);
    check("s1011_env", env, 31);
    check("s1011_held", env_held, 1);

    // shape_wr coincident with cen at step 17: tick discarded
    eg_period = 16'd2;
    write_shape(4'b1100, 1'b0);
    for (int k = 0; k < 17; k++) step_wait(4, nc);
    check("mid_env17", env, 17);
    cen = 1'b1;                 // counter is at 0; this tick alone would not step
    cyc();
    cen = 1'b0;
    check("mid_pre_step", env_step, 0);
    write_shape(4'b1100, 1'b1); // this tick would have completed the period
    check("mid_restart_env", env, 0);
    check("mid_restart_step", env_step, 0);
    step_wait(4, nc);
    check("mid_discard_ncen", nc, 2);
    check("mid_env1", env, 1);

    // period shrink 100 -> 3 with counter at 50, then period 0
    eg_period = 16'd100;
    write_shape(4'b1100, 1'b0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      cen = 1'b1;
      cyc();
      cen = 1'b0;
      if (env_step) seen++;
    end
    check("p100_nostep", seen, 0);
    eg_period = 16'd3;
    step_wait(4, nc);
    check("shrink_ncen", nc, 1);
    check("shrink_env", env, 1);
    step_wait(6, nc);
    check("p3_ncen_a", nc, 3);
    step_wait(6, nc);
    check("p3_ncen_b", nc, 3);
    check("p3_env", env, 3);
    eg_period = 16'd0;
    step_wait(4, nc);
    check("p0_ncen_a", nc, 1);
    step_wait(4, nc);
    check("p0_ncen_b", nc, 1);
    check("p0_env", env, 5);

    // reset mid-envelope aborts immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_env", env, 0);
    check("arst_held", env_held, 1);
    check("arst_step", env_step, 0);
    cyc();
    rst_n = 1'b1;
    step_wait(5, nc);
    check("arst_nostep", nc, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
